// File: rtl/led_driver_model.sv
// led_driver_model: receiving end of the LED-driver serial interface. Models one
// constant-current sink driver running on the system clock: shifts sdi on sclk
// rising edges, latches on le rising edges, and detects the 5-edge mode-switch
// pattern on (oe_n, le). In special mode, le loads the config register. Holding
// oe_n low captures the led_fault status into the shift register, where it can be
// read back on sdo.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   sclk, sdi, le     serial clock, data and latch enable (synchronous to clk)
//   oe_n              output enable, active low
//   led_fault         per-channel open-circuit status (1 = fault)
//   sdo               serial out, registered copy of the shift register MSB
//   led_on            channel sink enables
//   config_out        configuration register ('config' is a reserved word)
//   special_mode      1 = special (config/error) mode
//   mode_changed      one-clk pulse when the mode flips
//   err_captured      one-clk pulse when led_fault is loaded into the shift register
module led_driver_model #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned CFG_WIDTH      = 8,
    parameter int unsigned ERR_DET_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sclk,
    input  logic                 sdi,
    input  logic                 le,
    input  logic                 oe_n,
    input  logic [WIDTH-1:0]     led_fault,
    output logic                 sdo,
    output logic [WIDTH-1:0]     led_on,
    output logic [CFG_WIDTH-1:0] config_out,
    output logic                 special_mode,
    output logic                 mode_changed,
    output logic                 err_captured
);

    localparam int unsigned    CntW   = $clog2(ERR_DET_CYCLES + 1);
    localparam logic [CntW-1:0] ErrMax = CntW'(ERR_DET_CYCLES);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    // Mode patterns, oldest sample in the MSB, current sample in the LSB.
    localparam logic [4:0] PatOe      = 5'b10111;
    localparam logic [4:0] PatLeSpec  = 5'b00010;
    localparam logic [4:0] PatLeNorm  = 5'b00000;

    logic                 sclk_d_q, le_d_q;
    logic [WIDTH-1:0]     shift_reg_q, shift_reg_d;
    logic                 sdo_q, sdo_d;
    logic [WIDTH-1:0]     data_latch_q, data_latch_d;
    logic [CFG_WIDTH-1:0] config_q, config_d;
    logic [WIDTH-1:0]     led_on_q, led_on_d;
    logic                 special_mode_q, special_mode_d;
    logic                 mode_changed_q, mode_changed_d;
    logic                 err_captured_q, err_captured_d;
    // Four most recent prior (oe_n, le) samples; bit 0 is the newest.
    logic [3:0]           hist_oe_q, hist_oe_d;
    logic [3:0]           hist_le_q, hist_le_d;
    logic [2:0]           hist_cnt_q, hist_cnt_d;
    logic [CntW-1:0]      err_cnt_q, err_cnt_d;

    logic sclk_rise, le_rise, err_load;
    logic pat_oe_ok, pat_spec, pat_norm;

    always_comb begin
        sclk_rise = sclk & ~sclk_d_q;
        le_rise   = le & ~le_d_q;

        // Fault capture fires once, on the cycle the low-oe_n count saturates.
        err_cnt_d = '0;
        err_load  = 1'b0;
        if (special_mode_q && !oe_n) begin
            if (err_cnt_q != ErrMax) begin
                err_cnt_d = err_cnt_q + CntOne;
                err_load  = (err_cnt_q == ErrMax - CntOne);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end
        err_captured_d = err_load;

        shift_reg_d = shift_reg_q;
        if (err_load) begin
            shift_reg_d = led_fault;
        end else if (sclk_rise) begin
            shift_reg_d = {shift_reg_q[WIDTH-2:0], sdi};
        end
        sdo_d = shift_reg_q[WIDTH-1];

        // Latch uses the pre-shift register even when sclk rises in the same cycle.
        data_latch_d = data_latch_q;
        config_d     = config_q;
        if (le_rise) begin
            if (special_mode_q) begin
                config_d = shift_reg_q[CFG_WIDTH-1:0];
            end else begin
                data_latch_d = shift_reg_q;
            end
        end

        led_on_d = oe_n ? '0 : data_latch_q;

        pat_oe_ok      = ({hist_oe_q, oe_n} == PatOe);
        pat_spec       = ({hist_le_q, le} == PatLeSpec);
        pat_norm       = ({hist_le_q, le} == PatLeNorm);
        hist_oe_d      = hist_oe_q;
        hist_le_d      = hist_le_q;
        hist_cnt_d     = hist_cnt_q;
        special_mode_d = special_mode_q;
        mode_changed_d = 1'b0;
        if (sclk_rise) begin
            if ((hist_cnt_q >= 3'd4) && pat_oe_ok && (pat_spec || pat_norm)) begin
                hist_oe_d      = '0;
                hist_le_d      = '0;
                hist_cnt_d     = '0;
                special_mode_d = pat_spec;
                mode_changed_d = (pat_spec != special_mode_q);
            end else begin
                hist_oe_d = {hist_oe_q[2:0], oe_n};
                hist_le_d = {hist_le_q[2:0], le};
                if (hist_cnt_q != 3'd5) begin
                    hist_cnt_d = hist_cnt_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_d_q       <= 1'b0;
            le_d_q         <= 1'b0;
            shift_reg_q    <= '0;
            sdo_q          <= 1'b0;
            data_latch_q   <= '0;
            config_q       <= '1;
            led_on_q       <= '0;
            special_mode_q <= 1'b0;
            mode_changed_q <= 1'b0;
            err_captured_q <= 1'b0;
            hist_oe_q      <= '0;
            hist_le_q      <= '0;
            hist_cnt_q     <= '0;
            err_cnt_q      <= '0;
        end else begin
            sclk_d_q       <= sclk;
            le_d_q         <= le;
            shift_reg_q    <= shift_reg_d;
            sdo_q          <= sdo_d;
            data_latch_q   <= data_latch_d;
            config_q       <= config_d;
            led_on_q       <= led_on_d;
            special_mode_q <= special_mode_d;
            mode_changed_q <= mode_changed_d;
            err_captured_q <= err_captured_d;
            hist_oe_q      <= hist_oe_d;
            hist_le_q      <= hist_le_d;
            hist_cnt_q     <= hist_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign sdo          = sdo_q;
    assign led_on       = led_on_q;
    assign config_out   = config_q;
    assign special_mode = special_mode_q;
    assign mode_changed = mode_changed_q;
    assign err_captured = err_captured_q;

endmodule

// File: tb/tb_led_driver_model.sv
// Directed testbench for led_driver_model: shift/latch, mode switching, fault
// capture and readback, reset discarding history, same-cycle shift and latch.
module tb_led_driver_model;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sclk, sdi, le, oe_n;
    logic [15:0] led_fault;
    logic        sdo;
    logic [15:0] led_on;
    logic [7:0]  config_out;
    logic        special_mode, mode_changed, err_captured;

    int tests_run    = 0;
    int tests_failed = 0;
    int mc_count     = 0;
    int ec_count     = 0;

    led_driver_model #(
        .WIDTH         (16),
        .CFG_WIDTH     (8),
        .ERR_DET_CYCLES(3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sclk        (sclk),
        .sdi         (sdi),
        .le          (le),
        .oe_n        (oe_n),
        .led_fault   (led_fault),
        .sdo         (sdo),
        .led_on      (led_on),
        .config_out  (config_out),
        .special_mode(special_mode),
        .mode_changed(mode_changed),
        .err_captured(err_captured)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (mode_changed === 1'b1) mc_count++;
        if (err_captured === 1'b1) ec_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One serial bit: sclk high for one clk, low for one clk; le follows sclk.
    task automatic sclk_bit(input logic d, input logic o, input logic l);
        sdi  = d;
        oe_n = o;
        le   = l;
        sclk = 1'b1;
        tick();
        sclk = 1'b0;
        le   = 1'b0;
        tick();
    endtask

    task automatic shift_word(input logic [15:0] w, input logic o);
        for (int i = 15; i >= 0; i--) sclk_bit(w[i], o, 1'b0);
    endtask

    task automatic pulse_le();
        le = 1'b1;
        tick();
        le = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sclk = 1'b0; sdi = 1'b0; le = 1'b0; oe_n = 1'b1;
        led_fault = 16'h0000;
        repeat (2) tick();
        @(negedge clk);
        tests_run++;
        if (sdo !== 1'b0) begin
            tests_failed++; $display("FAIL reset_sdo: got %b expected 0", sdo);
        end
        tests_run++;
        if (led_on !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_led_on: got %h expected 0000", led_on);
        end
        tests_run++;
        if (config_out !== 8'hFF) begin
            tests_failed++; $display("FAIL reset_config: got %h expected ff", config_out);
        end
        tests_run++;
        if (special_mode !== 1'b0) begin
            tests_failed++; $display("FAIL reset_special: got %b expected 0", special_mode);
        end
        tests_run++;
        if ({mode_changed, err_captured} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b%b expected 00", mode_changed, err_captured);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_shift_latch();
        shift_word(16'hA5C3, 1'b1);
        @(negedge clk);
        tests_run++;
        if (sdo !== 1'b1) begin
            tests_failed++; $display("FAIL shift_sdo_msb: got %b expected 1", sdo);
        end
        pulse_le();
        @(negedge clk);
        tests_run++;
        if (led_on !== 16'h0000) begin
            tests_failed++; $display("FAIL latch_oe_off: got %h expected 0000", led_on);
        end
        oe_n = 1'b0;
        #1;
        tests_run++;
        if (led_on !== 16'h0000) begin
            tests_failed++; $display("FAIL led_on_latency: got %h expected 0000", led_on);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (led_on !== 16'hA5C3) begin
            tests_failed++; $display("FAIL led_on_data: got %h expected a5c3", led_on);
        end
        oe_n = 1'b1;
        tick();
        @(negedge clk);
        tests_run++;
        if (led_on !== 16'h0000) begin
            tests_failed++; $display("FAIL led_on_off: got %h expected 0000", led_on);
        end
    endtask

    task automatic test_special_entry();
        int mc0;
        mc0 = mc_count;
        sclk_bit(1'b0, 1'b1, 1'b0);
        sclk_bit(1'b0, 1'b0, 1'b0);
        sclk_bit(1'b0, 1'b1, 1'b0);
        sclk_bit(1'b0, 1'b1, 1'b1);
        sclk_bit(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        tests_run++;
        if (special_mode !== 1'b1) begin
            tests_failed++; $display("FAIL special_enter: got %b expected 1", special_mode);
        end
        tests_run++;
        if (mc_count - mc0 != 1) begin
            tests_failed++;
            $display("FAIL special_pulse: got %0d pulses expected 1", mc_count - mc0);
        end
        shift_word(16'h0040, 1'b1);
        pulse_le();
        @(negedge clk);
        tests_run++;
        if (config_out !== 8'h40) begin
            tests_failed++; $display("FAIL config_load: got %h expected 40", config_out);
        end
        tests_run++;
        if (led_on !== 16'h0000) begin
            tests_failed++; $display("FAIL config_led_on: got %h expected 0000", led_on);
        end
    endtask

    task automatic test_error_capture();
        int          ec0;
        logic [15:0] rx;
        ec0       = ec_count;
        led_fault = 16'h0081;
        oe_n      = 1'b0;
        tick();
        tick();
        @(negedge clk);
        tests_run++;
        if (err_captured !== 1'b0) begin
            tests_failed++; $display("FAIL err_early: got %b expected 0", err_captured);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (err_captured !== 1'b1) begin
            tests_failed++; $display("FAIL err_pulse: got %b expected 1", err_captured);
        end
        // data_latch was loaded by the le pulse inside the special pattern (A5C3 << 3).
        tests_run++;
        if (led_on !== 16'h2E18) begin
            tests_failed++; $display("FAIL special_latch: got %h expected 2e18", led_on);
        end
        repeat (5) tick();
        oe_n = 1'b1;
        tick();
        @(negedge clk);
        tests_run++;
        if (ec_count - ec0 != 1) begin
            tests_failed++;
            $display("FAIL err_single: got %0d captures expected 1", ec_count - ec0);
        end
        rx = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rx = {rx[14:0], sdo};
            sclk_bit(1'b0, 1'b1, 1'b0);
        end
        tests_run++;
        if (rx !== 16'h0081) begin
            tests_failed++; $display("FAIL err_readback: got %h expected 0081", rx);
        end
    endtask

    task automatic test_normal_exit();
        int mc0;
        mc0 = mc_count;
        for (int r = 0; r < 2; r++) begin
            sclk_bit(1'b0, 1'b1, 1'b0);
            sclk_bit(1'b0, 1'b0, 1'b0);
            sclk_bit(1'b0, 1'b1, 1'b0);
            sclk_bit(1'b0, 1'b1, 1'b0);
            sclk_bit(1'b0, 1'b1, 1'b0);
            @(negedge clk);
            tests_run++;
            if (special_mode !== 1'b0) begin
                tests_failed++;
                $display("FAIL normal_exit_%0d: got %b expected 0", r, special_mode);
            end
            tests_run++;
            if (mc_count - mc0 != 1) begin
                tests_failed++;
                $display("FAIL normal_pulse_%0d: got %0d pulses expected 1", r, mc_count - mc0);
            end
        end
        tests_run++;
        if (config_out !== 8'h40) begin
            tests_failed++; $display("FAIL config_kept: got %h expected 40", config_out);
        end
        sclk_bit(1'b0, 1'b1, 1'b0);
        sclk_bit(1'b0, 1'b0, 1'b0);
        sclk_bit(1'b0, 1'b1, 1'b0);
        sclk_bit(1'b0, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (config_out !== 8'hFF) begin
            tests_failed++; $display("FAIL async_reset_cfg: got %h expected ff", config_out);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        sclk_bit(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        tests_run++;
        if (special_mode !== 1'b0 || mc_count - mc0 != 1) begin
            tests_failed++;
            $display("FAIL partial_discard: got mode %b pulses %0d expected mode 0 pulses 1",
                     special_mode, mc_count - mc0);
        end
    endtask

    task automatic test_same_cycle();
        int mc0;
        shift_word(16'h1234, 1'b1);
        sclk_bit(1'b1, 1'b1, 1'b1);
        oe_n = 1'b0;
        tick();
        @(negedge clk);
        tests_run++;
        if (led_on !== 16'h1234) begin
            tests_failed++; $display("FAIL same_cycle_latch: got %h expected 1234", led_on);
        end
        mc0 = mc_count;
        for (int i = 0; i < 32; i++) sclk_bit((i % 2) == 1, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (special_mode !== 1'b0 || mc_count - mc0 != 0) begin
            tests_failed++;
            $display("FAIL toggle_no_mode: got mode %b pulses %0d expected mode 0 pulses 0",
                     special_mode, mc_count - mc0);
        end
        tests_run++;
        if (led_on !== 16'h1234) begin
            tests_failed++; $display("FAIL toggle_led_on: got %h expected 1234", led_on);
        end
        oe_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_shift_latch();
        test_special_entry();
        test_error_capture();
        test_normal_exit();
        test_same_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
